xtea_cipher_core: RTL and testbench

//   Iterative XTEA block cipher engine: enciphers or deciphers one 64-bit block under a 128-bit key.

---
 rtl/xtea_cipher_core.sv | 119 +++++++++++
 tb/tb_xtea_cipher_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xtea_cipher_core.sv
// Iterative XTEA engine: one full Feistel cycle (two half-rounds) per clock.
// A start pulse latches key/data/mode; all_done holds the result until the next start.
module xtea_cipher_core #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] key_in,
    input  logic [31:0]  data_in1,
    input  logic [31:0]  data_in2,
    output logic [31:0]  data_out1,
    output logic [31:0]  data_out2,
    output logic         busy,
    output logic         all_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] DEC_SUM = DELTA * ROUNDS;
    localparam logic [5:0]  LAST    = 6'(ROUNDS - 1);

    state_t        state_q;
    logic [5:0]    cnt_q;
    logic [31:0]   v0_q, v1_q, sum_q;
    logic [31:0]   v0_d, v1_d, sum_d;
    logic [127:0]  key_q;
    logic          mode_q;
    logic [31:0]   out1_q, out2_q;
    logic          busy_q, done_q;

    function automatic logic [31:0] f_mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    // k0 is the most significant key word.
    function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    // NOTE: blocking assignments here let the second half-round consume the
    // first half-round's result within the same cycle.
    always_comb begin
        v0_d  = v0_q;
        v1_d  = v1_q;
        sum_d = sum_q;
        if (!mode_q) begin
            v0_d  = v0_q + (f_mix(v1_q) ^ (sum_q + key_word(key_q, sum_q[1:0])));
            sum_d = sum_q + DELTA;
            v1_d  = v1_q + (f_mix(v0_d) ^ (sum_d + key_word(key_q, sum_d[12:11])));
        end else begin
            v1_d  = v1_q - (f_mix(v0_q) ^ (sum_q + key_word(key_q, sum_q[12:11])));
            sum_d = sum_q - DELTA;
            v0_d  = v0_q - (f_mix(v1_d) ^ (sum_d + key_word(key_q, sum_d[1:0])));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register (key store included) has an explicit async reset value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            out1_q  <= '0;
            out2_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            // Start wins in every state, so a block in flight is simply abandoned.
            state_q <= RUN;
            cnt_q   <= '0;
            v0_q    <= data_in1;
            v1_q    <= data_in2;
            sum_q   <= mode ? DEC_SUM : 32'd0;
            key_q   <= key_in;
            mode_q  <= mode;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    v0_q  <= v0_d;
                    v1_q  <= v1_d;
                    sum_q <= sum_d;
                    if (cnt_q == LAST) begin
                        out1_q  <= v0_d;
                        out2_q  <= v1_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out1 = out1_q;
    assign data_out2 = out2_q;
    assign busy      = busy_q;
    assign all_done  = done_q;

endmodule

// File: tb/tb_xtea_cipher_core.sv
// Scoreboard bench for xtea_cipher_core: a driver queues expected results and
// completion cycles; a monitor compares status and outputs every cycle.
module tb_xtea_cipher_core;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [127:0] key_in;
    logic [31:0]  data_in1, data_in2;
    logic [31:0]  data_out1, data_out2;
    logic         busy, all_done;

    xtea_cipher_core #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .key_in   (key_in),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_out1(data_out1),
        .data_out2(data_out2),
        .busy     (busy),
        .all_done (all_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] res;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] hold_out = '0;
    logic        done_flag = 1'b0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Straightforward XTEA loop over the full key schedule.
    function automatic logic [63:0] xtea_model(input logic m, input logic [127:0] k,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] kw[4];
        logic [31:0] y, z, s;
        for (int i = 0; i < 4; i++) kw[i] = k[127 - 32*i -: 32];
        y = a;
        z = b;
        if (!m) begin
            s = 32'd0;
            for (int r = 0; r < ROUNDS; r++) begin
                y += (((z << 4) ^ (z >> 5)) + z) ^ (s + kw[int'(s & 32'd3)]);
                s += DELTA;
                z += (((y << 4) ^ (y >> 5)) + y) ^ (s + kw[int'((s >> 11) & 32'd3)]);
            end
        end else begin
            s = DELTA * ROUNDS;
            for (int r = 0; r < ROUNDS; r++) begin
                z -= (((y << 4) ^ (y >> 5)) + y) ^ (s + kw[int'((s >> 11) & 32'd3)]);
                s -= DELTA;
                y -= (((z << 4) ^ (z >> 5)) + z) ^ (s + kw[int'(s & 32'd3)]);
            end
        end
        return {y, z};
    endfunction

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            if (sb.size() > 0 && cyc == sb[0].done_cyc) begin
                check("result", {2'b00, data_out1, data_out2}, {2'b00, sb[0].res});
                check("done_status", {64'd0, busy, all_done}, {64'd0, 2'b01});
                hold_out  = sb[0].res;
                done_flag = 1'b1;
                void'(sb.pop_front());
            end else if (sb.size() > 0 && cyc >= sb[0].start_cyc) begin
                check("run_status", {busy, all_done, data_out1, data_out2}, {2'b10, hold_out});
            end else begin
                check("idle_status", {busy, all_done, data_out1, data_out2},
                      {1'b0, done_flag, hold_out});
            end
        end
    end

    // Drive start for 'hold' consecutive edges, then scramble the inputs.
    task automatic issue(input logic m, input logic [127:0] k, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            start    = 1'b1;
            mode     = m;
            key_in   = k;
            data_in1 = a;
            data_in2 = b;
            sb.delete();
            done_flag = 1'b0;
            sb.push_back('{res: exp, start_cyc: cyc + 1, done_cyc: cyc + 1 + ROUNDS});
        end
        @(negedge clock);
        start    = 1'b0;
        mode     = ~m;
        key_in   = 'x;
        data_in1 = $urandom();
        data_in2 = $urandom();
    endtask

    task automatic wait_done();
        for (int i = 0; i < ROUNDS + 8 && sb.size() > 0; i++) @(negedge clock);
        check("completion_timeout", 66'(sb.size()), 66'd0);
        sb.delete();
    endtask

    logic [127:0] rk;
    logic [31:0]  ra, rb;
    logic         rm;

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        key_in = '0; data_in1 = '0; data_in2 = '0;
        #1;
        check("reset_state", {busy, all_done, data_out1, data_out2}, 66'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        issue(1'b0, 128'd0, 32'h0, 32'h0, 64'hdee9d4d8_f7131ed9, 1);
        wait_done();
        repeat (3) @(negedge clock);

        issue(1'b0, 128'h11111111222222223333333344444444, 32'h0, 32'h0, 64'hf07ac290_23c92672, 1);
        wait_done();
        issue(1'b1, 128'h11111111222222223333333344444444, 32'hf07ac290, 32'h23c92672, 64'h0, 1);
        wait_done();

        issue(1'b0, 128'h6a1d78c88c86d67f2a65bfbeb4bd6e46, 32'h12345678, 32'h9abcdeff,
              64'h99bbb92b_3ebd1644, 1);
        wait_done();
        issue(1'b1, 128'h6a1d78c88c86d67f2a65bfbeb4bd6e46, 32'h99bbb92b, 32'h3ebd1644,
              64'h12345678_9abcdeff, 1);
        wait_done();

        issue(1'b0, 128'h62ee209f69b7afce376a8936cdc9e923, 32'h1, 32'h1, 64'he57220dd_2622745b, 1);
        wait_done();

        // Abort a block part-way, restarting with the all-zero vector.
        issue(1'b0, 128'h0123456789abcdef0011223344556677, 32'hcafef00d, 32'h5a5aa5a5, 64'h0, 1);
        repeat (8) @(negedge clock);
        issue(1'b0, 128'd0, 32'h0, 32'h0, 64'hdee9d4d8_f7131ed9, 1);
        wait_done();

        // Asynchronous reset in the middle of a block, then a normal block.
        issue(1'b1, 128'h11111111222222223333333344444444, 32'h1, 32'h2, 64'h0, 1);
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b0;
        sb.delete();
        hold_out  = '0;
        done_flag = 1'b0;
        #1;
        check("reset_mid_run", {busy, all_done, data_out1, data_out2}, 66'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        issue(1'b0, 128'h11111111222222223333333344444444, 32'h0, 32'h0, 64'hf07ac290_23c92672, 1);
        wait_done();

        // Start held for three cycles: completion counts from the last one.
        issue(1'b0, 128'h62ee209f69b7afce376a8936cdc9e923, 32'h1, 32'h1, 64'he57220dd_2622745b, 3);
        wait_done();

        for (int n = 0; n < 24; n++) begin
            rm = 1'($urandom_range(0, 1));
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            ra = $urandom();
            rb = $urandom();
            issue(rm, rk, ra, rb, xtea_model(rm, rk, ra, rb), 1);
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
